// File: rtl/mac_multi_comparator_if.sv
// mac_multi_comparator_if: stream, table-config and status signals of the MAC comparator
interface mac_multi_comparator_if #(
  parameter int WORD_BYTES = 4,
  parameter int NUM_MACS = 4,
  parameter int CNT_WIDTH = 16
);
  localparam int IW = NUM_MACS > 1 ? $clog2(NUM_MACS) : 1;
  logic clear;
  logic [8*WORD_BYTES-1:0] data_in;
  logic [8*WORD_BYTES-1:0] data_out;
  logic match;
  logic [NUM_MACS-1:0] match_vec;
  logic [IW-1:0] match_idx;
  logic cfg_we;
  logic [IW-1:0] cfg_idx;
  logic [47:0] cfg_mac;
  logic [5:0] cfg_mask;
  logic cfg_en;
  logic [CNT_WIDTH-1:0] hit_count;
  modport master (
    output clear, data_in, cfg_we, cfg_idx, cfg_mac, cfg_mask, cfg_en,
    input data_out, match, match_vec, match_idx, hit_count
  );
  modport slave (
    input clear, data_in, cfg_we, cfg_idx, cfg_mac, cfg_mask, cfg_en,
    output data_out, match, match_vec, match_idx, hit_count
  );
endinterface

// File: rtl/mac_multi_comparator.sv
// mac_multi_comparator: multi-entry masked MAC search on a word stream with aligned delay line
module mac_multi_comparator #(
  parameter int WORD_BYTES = 4,
  parameter int NUM_MACS = 4,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  mac_multi_comparator_if.slave bus
);
  localparam int S = (2 * WORD_BYTES + 4) / WORD_BYTES;
  localparam int LAT = S + 1;
  localparam int SB = WORD_BYTES + 5;
  localparam int IW = NUM_MACS > 1 ? $clog2(NUM_MACS) : 1;

  logic [47:0] mac_t [NUM_MACS];
  logic [5:0] mask_t [NUM_MACS];
  logic [NUM_MACS-1:0] en_t;
  logic [39:0] hist;
  logic [2:0] fill;
  logic [2:0] fill_next;
  logic [8*SB-1:0] s;
  logic [NUM_MACS-1:0] hit_c [S];
  logic [NUM_MACS-1:0] hit_r [S];
  logic [8*WORD_BYTES-1:0] d [LAT];
  logic [NUM_MACS-1:0] mv [LAT];
  logic [IW-1:0] idx;
  logic [CNT_WIDTH-1:0] cnt;

  assign s = {hist, bus.data_in};
  assign fill_next = (int'(fill) + WORD_BYTES >= 6) ? 3'd6 : fill + 3'(WORD_BYTES);

  // table writes; rst wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < NUM_MACS; e++) begin
        mac_t[e] <= '0;
        mask_t[e] <= '1;
      end
      en_t <= '0;
    end else if (bus.cfg_we && int'(bus.cfg_idx) < NUM_MACS) begin
      mac_t[bus.cfg_idx] <= bus.cfg_mac;
      mask_t[bus.cfg_idx] <= bus.cfg_mask;
      en_t[bus.cfg_idx] <= bus.cfg_en;
    end
  end

  // every window ending in the current word vs every entry, binned by words back to its first byte
  always_comb begin
    logic [47:0] win;
    logic ok;
    for (int j = 0; j < S; j++) hit_c[j] = '0;
    for (int k = 0; k < WORD_BYTES; k++) begin
      win = s[8*(SB-k)-1 -: 48];
      for (int e = 0; e < NUM_MACS; e++) begin
        ok = en_t[e] && (int'(fill) + k + 1 >= 6);
        for (int b = 0; b < 6; b++)
          ok = ok && (!mask_t[e][5-b] || win[47-8*b -: 8] == mac_t[e][47-8*b -: 8]);
        if (ok) hit_c[(k >= 5) ? 0 : (5 - k + WORD_BYTES - 1) / WORD_BYTES][e] = 1'b1;
      end
    end
  end

  // history, registered hits, and delay line with per-stage OR-in of hits
  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      hist <= '0;
      fill <= '0;
      for (int j = 0; j < S; j++) hit_r[j] <= '0;
      for (int i = 0; i < LAT; i++) begin
        d[i] <= '0;
        mv[i] <= '0;
      end
    end else begin
      hist <= s[39:0];
      fill <= fill_next;
      hit_r <= hit_c;
      d[0] <= bus.data_in;
      mv[0] <= '0;
      for (int i = 1; i < LAT; i++) begin
        d[i] <= d[i-1];
        mv[i] <= mv[i-1] | hit_r[i-1];
      end
    end
  end

  // lowest matching entry of the output word
  always_comb begin
    idx = '0;
    for (int e = NUM_MACS - 1; e >= 0; e--) idx = mv[LAT-1][e] ? IW'(e) : idx;
  end

  // saturating count of output words carrying a match
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else if (|mv[LAT-1] && !(&cnt)) cnt <= cnt + 1'b1;
  end

  assign bus.data_out = d[LAT-1];
  assign bus.match_vec = mv[LAT-1];
  assign bus.match = |mv[LAT-1];
  assign bus.match_idx = idx;
  assign bus.hit_count = cnt;
endmodule

// File: tb/tb_mac_multi_comparator.sv
// tb_mac_multi_comparator: directed vectors with queued expectations checked by a monitor
module tb_mac_multi_comparator;
  localparam int W = 4, N = 4, CW = 2, LAT = 4;
  localparam logic [47:0] MAC0 = 48'h01B2C3D4E5F6;

  typedef struct {
    int due;
    logic [31:0] data;
    logic [3:0] vec;
    bit chk_cnt;
    logic [1:0] cnt;
    string name;
  } exp_t;

  logic clk = 0;
  logic rst;
  int ec = 0;
  int checks = 0, errors = 0;
  exp_t q[$];

  mac_multi_comparator_if #(.WORD_BYTES(W), .NUM_MACS(N), .CNT_WIDTH(CW)) bus ();
  mac_multi_comparator #(.WORD_BYTES(W), .NUM_MACS(N), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ec <= ec + 1;

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].due == ec) begin
      exp_t e;
      int xi;
      bit ok;
      e = q.pop_front();
      xi = 0;
      for (int b = 3; b >= 0; b--) if (e.vec[b]) xi = b;
      ok = bus.data_out === e.data && bus.match === (|e.vec) && bus.match_vec === e.vec &&
           bus.match_idx === 2'(xi) && (!e.chk_cnt || bus.hit_count === e.cnt);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s: got data_out=%h match=%b vec=%b idx=%0d cnt=%0d, expected data_out=%h match=%b vec=%b idx=%0d cnt=%0d",
                 e.name, bus.data_out, bus.match, bus.match_vec, bus.match_idx, bus.hit_count,
                 e.data, |e.vec, e.vec, xi, e.chk_cnt ? e.cnt : bus.hit_count);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int due, input logic [31:0] data, input logic [3:0] vec,
                      input bit cc, input logic [1:0] c, input string nm);
    exp_t e;
    e.due = due; e.data = data; e.vec = vec; e.chk_cnt = cc; e.cnt = c; e.name = nm;
    q.push_back(e);
  endtask

  task automatic send(input logic [31:0] w, input logic [3:0] v, input string nm,
                      input bit cc = 0, input logic [1:0] c = 0);
    bus.data_in = w;
    tick();
    push(ec + LAT - 1, w, v, cc, c, nm);
  endtask

  task automatic idle();
    bus.data_in = 32'hFFFF_FFFF;
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && q.size() > 0; i++) idle();
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic clr(input bit do_drain);
    if (do_drain) drain();
    bus.clear = 1;
    bus.data_in = $urandom;
    tick();
    bus.clear = 0;
    q.delete();
    push(ec, 32'h0, 4'b0, 0, 0, "after_clear");
  endtask

  task automatic do_rst(input bit we);
    drain();
    rst = 1;
    bus.clear = 1;
    bus.cfg_we = we;
    bus.cfg_idx = 0;
    bus.cfg_mac = MAC0;
    bus.cfg_mask = 6'h3F;
    bus.cfg_en = 1;
    bus.data_in = $urandom;
    tick();
    bus.data_in = $urandom;
    tick();
    rst = 0;
    bus.clear = 0;
    bus.cfg_we = 0;
    q.delete();
    push(ec, 32'h0, 4'b0, 1, 2'd0, "reset");
  endtask

  task automatic wr(input logic [1:0] i, input logic [47:0] m, input logic [5:0] k, input logic en);
    bus.cfg_idx = i;
    bus.cfg_mac = m;
    bus.cfg_mask = k;
    bus.cfg_en = en;
    bus.cfg_we = 1;
    bus.data_in = 32'hFFFF_FFFF;
    tick();
    bus.cfg_we = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [1:0] sat_cnt [5];
    sat_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1;
    bus.clear = 0;
    bus.cfg_we = 0;
    bus.cfg_idx = 0;
    bus.cfg_mac = 0;
    bus.cfg_mask = 0;
    bus.cfg_en = 0;
    bus.data_in = 0;
    do_rst(0);
    wr(0, MAC0, 6'h3F, 0);
    clr(1);
    send(32'h01B2C3D4, 4'b0000, "disabled_w0");
    send(32'hE5F60000, 4'b0000, "disabled_w1");
    send(32'h00000000, 4'b0000, "disabled_w2");
    wr(0, MAC0, 6'h3F, 1);
    clr(1);
    send(32'h01B2C3D4, 4'b0001, "aligned_w0");
    send(32'hE5F60000, 4'b0000, "aligned_w1", 1, 2'd1);
    send(32'h00000000, 4'b0000, "aligned_w2");
    clr(1);
    send(32'h0001B2C3, 4'b0001, "off1_w0");
    send(32'hD4E5F600, 4'b0000, "off1_w1");
    clr(1);
    send(32'h000001B2, 4'b0001, "off2_w0");
    send(32'hC3D4E5F6, 4'b0000, "off2_w1");
    clr(1);
    send(32'h00000001, 4'b0001, "off3_w0");
    send(32'hB2C3D4E5, 4'b0000, "off3_w1");
    send(32'hF6000000, 4'b0000, "off3_w2");
    wr(2, 48'h01B2C3000000, 6'h38, 1);
    wr(3, MAC0, 6'h3F, 0);
    clr(1);
    send(32'h01B2C3D4, 4'b0101, "multi_w0");
    send(32'hE5F60000, 4'b0000, "multi_w1");
    send(32'h00000000, 4'b0000, "multi_w2");
    wr(0, MAC0, 6'h3F, 0);
    clr(1);
    send(32'h01B2C3D4, 4'b0100, "mask_only_w0");
    send(32'hE5F60000, 4'b0000, "mask_only_w1");
    send(32'h00000000, 4'b0000, "mask_only_w2");
    clr(1);
    bus.data_in = 32'h01B2C3D4;
    tick();
    clr(0);
    send(32'hE5F60000, 4'b0000, "split_w1");
    send(32'h00000000, 4'b0000, "split_w2");
    wr(1, 48'h0, 6'h3F, 1);
    clr(1);
    for (int i = 0; i < 4; i++) send(32'hFFFFFFFF, 4'b0000, "stale_ff");
    send(32'h00000000, 4'b0010, "zero_w0");
    send(32'h00000000, 4'b0000, "zero_w1");
    do_rst(1);
    clr(1);
    send(32'h01B2C3D4, 4'b0000, "rst_we_w0");
    send(32'hE5F60000, 4'b0000, "rst_we_w1");
    wr(0, MAC0, 6'h3F, 1);
    for (int i = 0; i < 5; i++) begin
      clr(1);
      send(32'h01B2C3D4, 4'b0001, "sat_w0");
      send(32'hE5F60000, 4'b0000, "sat_w1", 1, sat_cnt[i]);
    end
    do_rst(0);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mac_multi_comparator.md
# mac_multi_comparator

Parametrised successor to the single-address MAC comparator on the sniffer datapath. Scans a continuous stream of `WORD_BYTES`-wide words for any of `NUM_MACS` programmable 48-bit MAC addresses at every byte alignment, with a per-byte compare mask per entry. Passes the stream through a fixed-latency delay line and flags the output word that holds the first byte of each match. Sits between the receive word assembler and the packet-flag/storage logic.

## Interface
- `WORD_BYTES`, default 4: bytes per data word, minimum 1.
- `NUM_MACS`, default 4: number of table entries, minimum 1.
- `CNT_WIDTH`, default 16: width of `hit_count`.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `clear`  in  1: synchronous flush of stream state at a frame boundary.
- `data_in`  in  8*WORD_BYTES: stream word, consumed every cycle. MSB byte is the earliest on the wire.
- `data_out`  out  8*WORD_BYTES: `data_in` delayed by LAT cycles.
- `match`  out  1: `data_out` holds the first byte of at least one match.
- `match_vec`  out  NUM_MACS: entries that matched starting in the `data_out` word. Bit i means entry i.
- `match_idx`  out  max(1,$clog2(NUM_MACS)): lowest set bit of `match_vec`. It is 0 when `match` = 0.
- `cfg_we`  in  1: table write strobe.
- `cfg_idx`  in  max(1,$clog2(NUM_MACS)): entry written. Out-of-range writes are ignored.
- `cfg_mac`  in  48: address. `cfg_mac[47:40]` is the first byte on the wire.
- `cfg_mask`  in  6: byte compare enable. Bit 5 is the first byte; 1 means compare.
- `cfg_en`  in  1: entry enable.
- `hit_count`  out  CNT_WIDTH: number of output words with `match` = 1, saturating.

## Operation
- Derived constants:
  - S = ceil((WORD_BYTES+5)/WORD_BYTES). This is the maximum number of words one MAC spans (3 at default).
  - LAT = S+1 (4 at default).
- Table:
  - Each entry holds {mac, mask, en}.
  - On `cfg_we`, entry `cfg_idx` is loaded at the clock edge. The new value applies to comparisons made in the next cycle.
  - The table is unaffected by `clear`.
- Byte history:
  - Shift register of the last 5 bytes plus the current word.
  - A fill counter saturates at 6 and counts bytes received since the last `rst`/`clear`.
- Compare:
  - Each cycle, for every byte position k in the current word, the 6-byte window ending at k is compared with every enabled entry.
  - A byte compares when its mask bit is 0 or the bytes are equal.
  - A window counts only when the fill counter shows that all 6 of its bytes arrived since the last flush. Bytes left over from a cleared history never match.
- Mask all-zero with an enabled entry: that entry matches every fully-filled window.
- Alignment: a hit is attributed to the word holding the window's first byte, which is 0..S-1 words back. The per-stage `match_vec` bit of that word is ORed in, so it emerges together with that word on `data_out`.
- Multiple hits on the same word, from different offsets or entries, merge into one `match` and OR into `match_vec`.
- `hit_count` increments by 1 per output cycle with `match` = 1 and holds at all-ones. It is cleared only by `rst`.
- `clear`:
  - Zeroes byte history, fill counter, delay line and match pipeline at the edge.
  - `data_out`, `match`, `match_vec` and `match_idx` read 0 from the next cycle until new data propagates.
  - A MAC split across a `clear` is not detected.
  - `data_in` in the `clear` cycle is discarded.
- `rst`: as `clear`, plus all table entries reset to mac=0, mask=6'b111111, en=0, and `hit_count` reset to 0.
- `rst` and `clear` together behave as `rst`. `cfg_we` together with `rst` is ignored.

## Timing
- A word sampled at edge t appears on `data_out` in the cycle after edge t+LAT-1, i.e. LAT cycles later.
- `match`, `match_vec` and `match_idx` are registered and aligned with that `data_out` word.
- Reset value of all outputs is 0.
- No handshake: one word per cycle, no backpressure. Gaps must be sent as idle words or bracketed by `clear`.
- Comparisons are registered once; the match pipeline is a LAT-deep shift register with a per-stage OR-in port. There is no combinational path from input to output.

## Test plan
All scenarios use WORD_BYTES=4, NUM_MACS=4.

1. **Reset.** Assert `rst` 2 cycles with random `data_in`. Required: `data_out`=0, `match`=0, `match_vec`=0, `hit_count`=0. Entry 0 = 01B2C3D4E5F6 still does not match, because entries are disabled.
2. **Aligned match.** Entry 0 = 01B2C3D4E5F6, mask 3F, en. After `clear`, send 01B2C3D4, E5F60000, 00000000.
   - 4 cycles after the first word: `data_out`=01B2C3D4, `match`=1, `match_vec`=0001, `match_idx`=0.
   - Next cycle: E5F60000 with `match`=0. `hit_count`=1.
3. **Offsets 1, 2, 3.** Send each sequence separately after a `clear`:
   - 0001B2C3, D4E5F600
   - 000001B2, C3D4E5F6
   - 00000001, B2C3D4E5, F6000000

   Required: `match`=1 only with the first word of each sequence, at LAT=4.
4. **Masks and multi-entry.**
   - Setup: entry 2 = 01B2C3000000, mask 38, en. Entry 3 = same as entry 0 but en=0.
   - Stimulus: repeat scenario 2.
   - Required: `match_vec`=0101, `match_idx`=0.
   - Then rewrite entry 0 with en=0 and repeat. Required: `match_vec`=0100, `match_idx`=2.
5. **Clear mid-address and stale history.**
   - Send 01B2C3D4, then `clear`, then E5F60000. Required: no match.
   - Set entry 1 = 000000000000, en. After `clear`, send FFFFFFFF ×4. Required: no match.
   - Then send 00000000 ×2. Required: `match_vec[1]`=1 only on the first 00000000 output word.
6. **Saturation.** Use CNT_WIDTH=2 and send 5 separate matching sequences. Required: `hit_count` reads 1, 2, 3, 3, 3. `rst` returns it to 0.
